// File: rtl/wb_bridge_pkg.sv
// Shared definitions for the Wishbone master bridge.
// Holds the FSM state type, the request/response field layout, the timeout
// counter width and a helper that packs a response word.
package wb_bridge_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StBus,
    StResp
  } state_e;

  // Request word: {we, sel[3:0], adr[31:0], dat[31:0]}
  localparam int unsigned ReqW      = 69;
  localparam int unsigned ReqWeBit  = 68;
  localparam int unsigned ReqSelLsb = 64;
  localparam int unsigned SelW      = 4;
  localparam int unsigned ReqAdrLsb = 32;
  localparam int unsigned AdrW      = 32;
  localparam int unsigned ReqDatLsb = 0;
  localparam int unsigned DatW      = 32;

  // Response word: {timeout, err, dat[31:0]}
  localparam int unsigned RespW      = 34;
  localparam int unsigned RespToBit  = 33;
  localparam int unsigned RespErrBit = 32;

  localparam int unsigned CntW = 8;

  function automatic logic [RespW-1:0] pack_resp(input logic to, input logic err,
                                                 input logic [DatW-1:0] dat);
    return {to, err, dat};
  endfunction

endpackage

// File: rtl/wb_master_bridge.sv
// Wishbone classic master bridge.
// Converts a valid/ready request stream into single Wishbone transactions and
// returns each result on a valid/ready response stream. One transaction is in
// flight at a time; a bus cycle that sees no ack/err is aborted after
// TIMEOUT_CYCLES cycles and reported with the timeout flag.
//
// Ports:
//   wb_clk_i, wb_rst_i          clock, asynchronous active-high reset
//   req_recv_msg/val/rdy        request {we, sel, adr, dat}
//   resp_send_msg/val/rdy       response {timeout, err, dat}
//   wbm_cyc_o/stb_o/we_o        Wishbone cycle, strobe, write enable
//   wbm_sel_o/adr_o/dat_o       Wishbone byte select, address, write data
//   wbm_dat_i/ack_i/err_i       Wishbone read data, acknowledge, error
//
// Every output comes straight from a register, so no input reaches an output
// combinationally.
module wb_master_bridge
  import wb_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic [ReqW-1:0]  req_recv_msg,
  input  logic             req_recv_val,
  output logic             req_recv_rdy,
  output logic [RespW-1:0] resp_send_msg,
  output logic             resp_send_val,
  input  logic             resp_send_rdy,
  output logic             wbm_cyc_o,
  output logic             wbm_stb_o,
  output logic             wbm_we_o,
  output logic [SelW-1:0]  wbm_sel_o,
  output logic [AdrW-1:0]  wbm_adr_o,
  output logic [DatW-1:0]  wbm_dat_o,
  input  logic [DatW-1:0]  wbm_dat_i,
  input  logic             wbm_ack_i,
  input  logic             wbm_err_i
);

  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 32'd1);

  state_e           state_q;
  logic [CntW-1:0]  cnt_q;
  logic             rdy_q;
  logic             cyc_q;
  logic             stb_q;
  logic             we_q;
  logic [SelW-1:0]  sel_q;
  logic [AdrW-1:0]  adr_q;
  logic [DatW-1:0]  dat_q;
  logic [RespW-1:0] resp_q;
  logic             resp_val_q;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      rdy_q      <= 1'b0;
      cyc_q      <= 1'b0;
      stb_q      <= 1'b0;
      we_q       <= 1'b0;
      sel_q      <= '0;
      adr_q      <= '0;
      dat_q      <= '0;
      resp_q     <= '0;
      resp_val_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_recv_val && rdy_q) begin
            we_q    <= req_recv_msg[ReqWeBit];
            sel_q   <= req_recv_msg[ReqSelLsb +: SelW];
            adr_q   <= req_recv_msg[ReqAdrLsb +: AdrW];
            // Reads put zero on the write-data bus.
            dat_q   <= req_recv_msg[ReqWeBit] ? req_recv_msg[ReqDatLsb +: DatW] : '0;
            cnt_q   <= '0;
            cyc_q   <= 1'b1;
            stb_q   <= 1'b1;
            rdy_q   <= 1'b0;
            state_q <= StBus;
          end else begin
            // Also raises ready on the first edge after reset release.
            rdy_q <= 1'b1;
          end
        end
        StBus: begin
          if (wbm_ack_i || wbm_err_i) begin
            // err dominates a simultaneous ack; writes return zero data.
            resp_q     <= wbm_err_i ? pack_resp(1'b0, 1'b1, '0)
                                    : pack_resp(1'b0, 1'b0, we_q ? '0 : wbm_dat_i);
            cyc_q      <= 1'b0;
            stb_q      <= 1'b0;
            resp_val_q <= 1'b1;
            state_q    <= StResp;
          end else if (cnt_q == CntLast) begin
            resp_q     <= pack_resp(1'b1, 1'b0, '0);
            cyc_q      <= 1'b0;
            stb_q      <= 1'b0;
            resp_val_q <= 1'b1;
            state_q    <= StResp;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StResp: begin
          if (resp_send_rdy) begin
            resp_val_q <= 1'b0;
            rdy_q      <= 1'b1;
            state_q    <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign req_recv_rdy  = rdy_q;
  assign resp_send_msg = resp_q;
  assign resp_send_val = resp_val_q;
  assign wbm_cyc_o     = cyc_q;
  assign wbm_stb_o     = stb_q;
  assign wbm_we_o      = we_q;
  assign wbm_sel_o     = sel_q;
  assign wbm_adr_o     = adr_q;
  assign wbm_dat_o     = dat_q;

endmodule

// File: doc/wb_master_bridge.md
WB_MASTER_BRIDGE -- requirements
Module: wb_master_bridge

Interface
REQ-001 The parameter list SHALL be: TIMEOUT_CYCLES, 255, maximum BUS-state cycles before abort (legal range 1..255).
REQ-002 Port: wb_clk_i  in  1  the single clock; all state updates on its rising edge.
REQ-003 Port: wb_rst_i  in  1  reset, asynchronous and active-high.
REQ-004 Port: req_recv_msg  in  69  request {we[68], sel[67:64], adr[63:32], dat[31:0]}.
REQ-005 Port: req_recv_val  in  1  request valid.
REQ-006 Port: req_recv_rdy  out  1  request ready.
REQ-007 Port: resp_send_msg  out  34  response {timeout[33], err[32], dat[31:0]}.
REQ-008 Port: resp_send_val  out  1  response valid.
REQ-009 Port: resp_send_rdy  in  1  response ready.
REQ-010 Ports: wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1 each  Wishbone master cycle/strobe/write.
REQ-011 Ports: wbm_sel_o  out  4; wbm_adr_o, wbm_dat_o  out  32  Wishbone byte select, address, write data.
REQ-012 Ports: wbm_dat_i  in  32; wbm_ack_i, wbm_err_i  in  1 each  Wishbone read data, acknowledge, error.

Function
REQ-013 The block SHALL implement FSM states IDLE, BUS, RESP; exactly one transaction outstanding at a time.
REQ-014 req_recv_rdy SHALL be 1 only in IDLE, driven from state register (no combinational path from any input).
REQ-015 IDLE: req_recv_val=1 at edge N SHALL latch we/sel/adr/dat, clear timeout counter, enter BUS; cyc/stb/we/sel/adr/dat outputs valid from cycle N+1.
REQ-016 BUS: wbm_cyc_o=wbm_stb_o=1, address/data/sel/we held stable; wbm_dat_o SHALL be 0 for reads.
REQ-017 BUS with wbm_ack_i=1 or wbm_err_i=1 at edge M: capture response, deassert cyc/stb from M+1, enter RESP; resp_send_val=1 from M+1.
REQ-018 Captured dat SHALL be wbm_dat_i for reads with ack, 0 for writes, 0 on err or timeout.
REQ-019 Simultaneous ack and err SHALL be treated as err (err=1, dat=0).
REQ-020 8-bit counter SHALL increment each BUS cycle without ack/err; when counter==TIMEOUT_CYCLES-1 with no ack/err, enter RESP with timeout=1, err=0, dat=0; cyc high exactly TIMEOUT_CYCLES cycles.
REQ-021 ack/err in the timeout cycle SHALL win over timeout.
REQ-022 wbm_ack_i/wbm_err_i outside BUS SHALL be ignored (no state change, no response).
REQ-023 RESP: resp_send_msg held stable while resp_send_val=1 and resp_send_rdy=0; on resp_send_rdy=1 return to IDLE, resp_send_val=0 next cycle.
REQ-024 Minimum latency: request accept to resp_send_val = 2 cycles (ack in first BUS cycle); back-to-back throughput one transaction per 3 cycles minimum.
REQ-025 wbm_cyc_o and wbm_stb_o SHALL never be 1 outside BUS.

Reset
REQ-026 wb_rst_i=1 SHALL immediately force IDLE, counter 0, all outputs 0 (req_recv_rdy=0 while reset held, 1 the first cycle after release).
REQ-027 Reset asserted mid-BUS SHALL drop cyc/stb asynchronously and discard the transaction with no response issued.

Structure
REQ-028 Shared package wb_bridge_pkg SHALL hold FSM state enum, request/response field offsets and widths, and TIMEOUT counter width.
REQ-029 No sub-module is required; FSM, capture registers and counter live in one module.

Verification
REQ-030 Read: req {we=0, sel=F, adr=0x30000010}, slave ack 3 cycles later with dat 0xDEADBEEF -> resp {0,0,0xDEADBEEF}, cyc high 3 cycles.
REQ-031 Write: req {we=1, sel=3, adr=0x30000004, dat=0x12345678}, immediate ack -> wbm_dat_o=0x12345678 while cyc, resp {0,0,0} two cycles after accept.
REQ-032 Error: read with err=1 and ack=1 same cycle -> resp {0,1,0}.
REQ-033 Timeout: TIMEOUT_CYCLES=4, no ack -> cyc high exactly 4 cycles, resp {1,0,0}; late ack afterward ignored.
REQ-034 Backpressure: resp_send_rdy=0 for 5 cycles -> resp_send_msg stable, req_recv_rdy=0 throughout, next request accepted the cycle after resp handshake.
REQ-035 Reset mid-BUS: assert wb_rst_i during cycle 2 of BUS -> cyc/stb 0 same cycle, no resp_send_val, req_recv_rdy=1 after release.
